// File: rtl/pulse_train_generator_pkg.sv
// Shared definitions for the pulse-train generator: default widths,
// FSM state encoding and the configuration sanity check.
package pulse_gen_pkg;

   localparam int TIME_W_DEF  = 16;
   localparam int COUNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   // A train needs a non-zero high time and at least one low tick per period.
   function automatic logic cfg_valid(input logic [31:0] width, input logic [31:0] period);
      return (width != 32'd0) && (period > width);
   endfunction

endpackage

// File: rtl/pulse_train_generator_if.sv
// Control-side bundle of the pulse-train generator: start/stop request,
// configuration, pulse output and status strobes.
interface pulse_train_generator_if
   import pulse_gen_pkg::*;
#(
   parameter int TIME_W  = TIME_W_DEF,
   parameter int COUNT_W = COUNT_W_DEF
);
   logic               START;
   logic               STOP;
   logic [TIME_W-1:0]  PULSE_WIDTH;
   logic [TIME_W-1:0]  PULSE_PERIOD;
   logic [COUNT_W-1:0] PULSE_COUNT;
   logic               PULSE_OUT;
   logic               BUSY;
   logic               DONE;
   logic               CFG_ERR;
   logic [COUNT_W-1:0] PULSE_IDX;

   // Control front-end side
   modport master (
      output START, STOP, PULSE_WIDTH, PULSE_PERIOD, PULSE_COUNT,
      input  PULSE_OUT, BUSY, DONE, CFG_ERR, PULSE_IDX
   );

   // Generator side
   modport slave (
      input  START, STOP, PULSE_WIDTH, PULSE_PERIOD, PULSE_COUNT,
      output PULSE_OUT, BUSY, DONE, CFG_ERR, PULSE_IDX
   );
endinterface

// File: rtl/pulse_train_generator_tick_counter.sv
// Tick counter for the pulse-train generator: counts enabled cycles,
// synchronous clear wins over enable, flags a match with the terminal value.
module pulse_tick_counter
   import pulse_gen_pkg::*;
#(
   parameter int TIME_W = TIME_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_en,
   input  logic              i_clr,
   input  logic [TIME_W-1:0] i_term,
   output logic              o_term
);
   logic [TIME_W-1:0] r_cnt;

   // Count enabled cycles; clear takes priority so a restart never sees a stale tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en)  r_cnt <= r_cnt + TIME_W'(1);
   end

   assign o_term = (r_cnt == i_term);
endmodule

// File: rtl/pulse_train_generator.sv
// Programmable pulse-train generator. Holds the IDLE/HIGH/LOW FSM, the
// configuration latched on START and the pulse index counter; time is
// measured in TICK_EN strobes by pulse_tick_counter.
module pulse_train_generator
   import pulse_gen_pkg::*;
#(
   parameter int TIME_W  = TIME_W_DEF,
   parameter int COUNT_W = COUNT_W_DEF
) (
   input  logic                   CLOCK_50MHZ,
   input  logic                   RESET_N,
   input  logic                   TICK_EN,
   pulse_train_generator_if.slave bus
);
   state_t             r_state;
   logic [TIME_W-1:0]  r_width;
   logic [TIME_W-1:0]  r_period;
   logic [COUNT_W-1:0] r_count;
   logic [COUNT_W-1:0] r_idx;
   logic               r_pulse;
   logic               r_busy;
   logic               r_done;
   logic               r_cfg_err;

   logic               w_active;
   logic               w_term;
   logic               w_last;
   logic               w_restart;
   logic               w_cfg_ok;
   logic [TIME_W-1:0]  w_term_val;

   assign w_active   = (r_state != ST_IDLE);
   assign w_cfg_ok   = cfg_valid(32'(bus.PULSE_WIDTH), 32'(bus.PULSE_PERIOD));
   // HIGH ends after W ticks, LOW ends when the whole period has elapsed.
   assign w_term_val = (r_state == ST_HIGH) ? r_width - TIME_W'(1) : r_period - TIME_W'(1);
   // PULSE_COUNT == 0 means continuous, so there is never a last pulse.
   assign w_last     = (r_count != '0) && (r_idx == r_count - COUNT_W'(1));
   assign w_restart  = (r_state == ST_LOW) && TICK_EN && w_term && !bus.STOP && !w_last;

   // Counter idles at zero, so HIGH always starts from tick 0.
   pulse_tick_counter #(.TIME_W(TIME_W)) u_tick (
      .clk    (CLOCK_50MHZ),
      .rst_n  (RESET_N),
      .i_en   (TICK_EN && w_active),
      .i_clr  (!w_active || bus.STOP || w_restart),
      .i_term (w_term_val),
      .o_term (w_term)
   );

   // Main FSM with registered outputs; STOP overrides any tick transition.
   always_ff @(posedge CLOCK_50MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state   <= ST_IDLE;
         r_width   <= '0;
         r_period  <= '0;
         r_count   <= '0;
         r_idx     <= '0;
         r_pulse   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
         if (w_active && bus.STOP) begin
            r_state <= ST_IDLE;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (bus.START && !bus.STOP) begin
                     if (w_cfg_ok) begin
                        r_width  <= bus.PULSE_WIDTH;
                        r_period <= bus.PULSE_PERIOD;
                        r_count  <= bus.PULSE_COUNT;
                        r_idx    <= '0;
                        r_state  <= ST_HIGH;
                        r_pulse  <= 1'b1;
                        r_busy   <= 1'b1;
                     end else begin
                        r_cfg_err <= 1'b1;
                     end
                  end
               end
               ST_HIGH: begin
                  if (TICK_EN && w_term) begin
                     r_state <= ST_LOW;
                     r_pulse <= 1'b0;
                  end
               end
               ST_LOW: begin
                  if (TICK_EN && w_term) begin
                     if (w_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= ST_HIGH;
                        r_pulse <= 1'b1;
                        r_idx   <= r_idx + COUNT_W'(1);
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.PULSE_OUT = r_pulse;
   assign bus.BUSY      = r_busy;
   assign bus.DONE      = r_done;
   assign bus.CFG_ERR   = r_cfg_err;
   assign bus.PULSE_IDX = r_idx;
endmodule
